// File: rtl/shift_sequencer.sv
// Multi-cycle Val2 shifter for the EXE stage: accepts one request per handshake,
// applies the shift one bit (or one rotate-by-2) per cycle, and holds the result for the consumer.
module shift_sequencer #(
  parameter int REGISTER_LEN = 32,
  parameter int CNT_W        = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [REGISTER_LEN-1:0] Rm,
  input  logic [11:0]             shift_operand,
  input  logic                    immd,
  input  logic                    is_mem_command,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [REGISTER_LEN-1:0] val2_out,
  output logic                    busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // The low two bits of the register encodings match shift_operand[6:5].
  typedef enum logic [2:0] {
    T_LSL  = 3'd0,
    T_LSR  = 3'd1,
    T_ASR  = 3'd2,
    T_ROR  = 3'd3,
    T_ROR2 = 3'd4
  } shift_t;

  state_t                  state_reg, state_next;
  shift_t                  type_reg, type_next;
  logic [CNT_W-1:0]        cnt_reg, cnt_next;
  logic [REGISTER_LEN-1:0] work_reg, work_next;
  logic [REGISTER_LEN-1:0] val2_reg, val2_next;

  logic                    accept;
  logic [REGISTER_LEN-1:0] load_work;
  shift_t                  load_type;
  logic [CNT_W-1:0]        load_cnt;

  logic [REGISTER_LEN-1:0] lsl_w, lsr_w, asr_w, ror_w, ror2_w;
  logic [REGISTER_LEN-1:0] step_w;

  assign accept = req_valid & req_ready;

  // Request decode. A register-specified amount (bit 4) degrades to an unshifted Rm.
  always_comb begin
    load_work = Rm;
    load_type = T_LSL;
    load_cnt  = '0;
    if (is_mem_command) begin
      load_work = REGISTER_LEN'(shift_operand);
    end else if (immd) begin
      load_work = REGISTER_LEN'(shift_operand[7:0]);
      load_type = T_ROR2;
      load_cnt  = CNT_W'(shift_operand[11:8]);
    end else if (!shift_operand[4]) begin
      load_type = shift_t'({1'b0, shift_operand[6:5]});
      load_cnt  = CNT_W'(shift_operand[11:7]);
    end
  end

  // Single-step candidates for every shift type, built bit by bit.
  genvar gi;
  generate
    for (gi = 0; gi < REGISTER_LEN; gi++) begin : g_step
      if (gi == 0) begin : g_lsb
        assign lsl_w[gi] = 1'b0;
      end else begin : g_mid
        assign lsl_w[gi] = work_reg[gi-1];
      end

      if (gi == REGISTER_LEN-1) begin : g_msb
        assign lsr_w[gi] = 1'b0;
        assign asr_w[gi] = work_reg[REGISTER_LEN-1];
      end else begin : g_low
        assign lsr_w[gi] = work_reg[gi+1];
        assign asr_w[gi] = work_reg[gi+1];
      end

      assign ror_w[gi]  = work_reg[(gi+1) % REGISTER_LEN];
      assign ror2_w[gi] = work_reg[(gi+2) % REGISTER_LEN];
    end
  endgenerate

  always_comb begin
    step_w = work_reg;
    case (type_reg)
      T_LSL:   step_w = lsl_w;
      T_LSR:   step_w = lsr_w;
      T_ASR:   step_w = asr_w;
      T_ROR:   step_w = ror_w;
      T_ROR2:  step_w = ror2_w;
      default: step_w = work_reg;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      type_reg  <= T_LSL;
      cnt_reg   <= '0;
      work_reg  <= '0;
      val2_reg  <= '0;
    end else begin
      state_reg <= state_next;
      type_reg  <= type_next;
      cnt_reg   <= cnt_next;
      work_reg  <= work_next;
      val2_reg  <= val2_next;
    end
  end

  // Next-state logic. flush overrides everything; accept already excludes flush.
  always_comb begin
    state_next = state_reg;
    type_next  = type_reg;
    cnt_next   = cnt_reg;
    work_next  = work_reg;
    val2_next  = val2_reg;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          state_next = IDLE;
        end
        SHIFT: begin
          work_next = step_w;
          cnt_next  = cnt_reg - CNT_W'(1);
          if (cnt_reg == CNT_W'(1)) begin
            state_next = DONE;
            val2_next  = step_w;
          end
        end
        DONE: begin
          if (out_ready) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase

      if (accept) begin
        work_next = load_work;
        type_next = load_type;
        cnt_next  = load_cnt;
        if (load_cnt == '0) begin
          state_next = DONE;
          val2_next  = load_work;
        end else begin
          state_next = SHIFT;
        end
      end
    end
  end

  // Outputs.
  always_comb begin
    req_ready = ~flush & ((state_reg == IDLE) | ((state_reg == DONE) & out_ready));
    out_valid = (state_reg == DONE);
    busy      = (state_reg == SHIFT) | ((state_reg == DONE) & ~out_ready);
    val2_out  = val2_reg;
  end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Multi-cycle Val2 shifter controller for the EXE stage.
- Accepts one Val2 request per handshake: Rm, the 12-bit shift_operand, immd and is_mem_command.
- Sequences an iterative shift, one step per cycle, and presents the 32-bit Val2 with a valid/ready handshake.
- Drives a stall to the hazard unit while a computation is in flight. It replaces the single-cycle shift path where timing requires it.

Parameters:
- REGISTER_LEN, 32, datapath width. Only 32 is supported.
- CNT_W, 5, width of the step counter. Must cover 0..31.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- flush  input  1  abort the in-flight request; synchronous to clk
- req_valid  input  1  request present
- req_ready  output  1  request accepted this cycle when req_valid is also high
- Rm  input  32  register operand
- shift_operand  input  12  instruction bits [11:0]
- immd  input  1  I bit: 1 = rotated immediate, 0 = register shift
- is_mem_command  input  1  LDR/STR offset form
- out_valid  output  1  val2_out holds a result
- out_ready  input  1  consumer takes the result
- val2_out  output  32  Val2 result
- busy  output  1  high in SHIFT, and in DONE while out_ready is low; used for pipeline stall

Behaviour:
- FSM states:
  - IDLE: waiting for a request.
  - SHIFT: counter nonzero, stepping.
  - DONE: result held.
- Reset (async, rst=1): state=IDLE, val2_out=0, out_valid=0, busy=0, counter=0, internal shift type=0.
- req_ready = ~flush & (state==IDLE | (state==DONE & out_ready)). This allows back-to-back requests with no bubble after DONE.
- On acceptance, the working register, counter and next state are loaded as follows:
  - is_mem_command=1 (highest priority): working = {20'b0, shift_operand}, count = 0.
  - immd=1: working = {24'b0, shift_operand[7:0]}, type = ROR2, count = shift_operand[11:8].
  - Otherwise: working = Rm, type = shift_operand[6:5] (00 LSL, 01 LSR, 10 ASR, 11 ROR), count = shift_operand[11:7].
  - shift_operand[4]=1 (register-specified amount) is not supported. It is treated as a zero count, and working = Rm.
  - If count==0, next state is DONE. Otherwise next state is SHIFT.
- SHIFT: one step per cycle, then count decrements. When count reaches 0 on this edge, next state is DONE.
  - ROR2: working = {w[1:0], w[31:2]}.
  - LSL: working = {w[30:0], 0}.
  - LSR: working = {0, w[31:1]}.
  - ASR: working = {w[31], w[31:1]}.
  - ROR: working = {w[0], w[31:1]}.
- Amount 0 means no shift for every type. The ARM LSR/ASR #32 and RRX encodings are not supported and yield the unshifted Rm.
- Latency from the accept edge to out_valid=1 is count+1 cycles: 1 cycle for mem, zero-count and immediate-rotate-0 requests; 32 cycles for a register shift by 31.
- DONE: out_valid=1 and val2_out=working.
  - val2_out and out_valid stay stable until out_ready=1.
  - On out_ready, the state goes to IDLE, or to the new request's state if req_valid is also accepted in the same cycle.
- val2_out is only meaningful while out_valid=1. Outside DONE it holds its last value.
- flush=1 has priority over everything except rst. The next state is IDLE, out_valid=0, and no request is accepted that cycle. A result in DONE is discarded even if out_ready=1.
- Reset mid-SHIFT or mid-DONE returns the block to IDLE immediately. No partial result is output.
- busy = (state==SHIFT) | (state==DONE & ~out_ready). busy is 0 in IDLE.

Test Plan:
- Mem command: req with is_mem_command=1 and shift_operand=12'hABC, Rm=32'hFFFFFFFF -> next cycle out_valid=1, val2_out=32'h00000ABC; busy=0 when out_ready=1.
- Immediate rotate: immd=1, shift_operand=12'h4FF (rot 4) -> out_valid 5 cycles after accept, val2_out=32'hFF000000; busy=1 during the 4 SHIFT cycles.
- Register shifts, Rm=32'h80000001:
  - LSL#4 (shift_operand=12'h200) -> 32'h00000010.
  - ASR#4 (12'h240) -> 32'hF8000000.
  - ROR#1 (12'h0E0) -> 32'hC0000000.
  - LSR#31 (12'hFA0) -> 32'h00000001, with 32-cycle latency.
- Backpressure: hold out_ready=0 for 3 cycles in DONE -> val2_out constant and busy=1; a new req_valid sees req_ready=0. Then raise out_ready with req_valid=1 -> same-cycle accept, and the next result follows without an idle bubble.
- Flush: flush=1 in the 2nd SHIFT cycle of LSL#8 -> next cycle IDLE, out_valid=0. flush asserted together with req_valid -> req_ready=0.
- Async reset: assert rst between clock edges during SHIFT -> state, out_valid and busy go to 0 immediately and val2_out=0. After release, a mem request works normally.
